// File: rtl/axi_wresp_router_if.sv
// Bus bundle for the M1 write-response router: AW handshake observation,
// per-slave B channels (S0, S1, default SD) and the merged B channel back to M1.
interface axi_wresp_router_if #(
  parameter int IDW_M = 4,
  parameter int IDW_S = 8
);
  logic [IDW_M-1:0] AWID_M1;
  logic             AWVALID_S0, AWREADY_S0;
  logic             AWVALID_S1, AWREADY_S1;
  logic             AWVALID_SD, AWREADY_SD;
  logic             AW_ALLOW;

  logic [IDW_S-1:0] BID_S0, BID_S1, BID_SD;
  logic [1:0]       BRESP_S0, BRESP_S1, BRESP_SD;
  logic             BVALID_S0, BVALID_S1, BVALID_SD;
  logic             BREADY_S0, BREADY_S1, BREADY_SD;

  logic [IDW_M-1:0] BID_M1;
  logic [1:0]       BRESP_M1;
  logic             BVALID_M1;
  logic             BREADY_M1;

  // Router side.
  modport slave (
    input  AWID_M1, AWVALID_S0, AWREADY_S0, AWVALID_S1, AWREADY_S1, AWVALID_SD, AWREADY_SD,
    input  BID_S0, BID_S1, BID_SD, BRESP_S0, BRESP_S1, BRESP_SD,
    input  BVALID_S0, BVALID_S1, BVALID_SD, BREADY_M1,
    output AW_ALLOW, BREADY_S0, BREADY_S1, BREADY_SD, BID_M1, BRESP_M1, BVALID_M1
  );

  // Environment side (AW arbiter, slaves and M1).
  modport master (
    output AWID_M1, AWVALID_S0, AWREADY_S0, AWVALID_S1, AWREADY_S1, AWVALID_SD, AWREADY_SD,
    output BID_S0, BID_S1, BID_SD, BRESP_S0, BRESP_S1, BRESP_SD,
    output BVALID_S0, BVALID_S1, BVALID_SD, BREADY_M1,
    input  AW_ALLOW, BREADY_S0, BREADY_S1, BREADY_SD, BID_M1, BRESP_M1, BVALID_M1
  );
endinterface

// File: rtl/axi_wresp_router.sv
// B-channel router for master M1: remembers which slave took the write address,
// returns that slave's response (or a synthesised DECERR on timeout) to M1.
module axi_wresp_router #(
  parameter int IDW_M  = 4,
  parameter int IDW_S  = 8,
  parameter int TO_CYC = 256
) (
  input logic               clk,
  input logic               rst,
  axi_wresp_router_if.slave bus
);
  localparam int              CNT_W       = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST    = (TO_CYC > 0) ? CNT_W'(TO_CYC - 1) : '0;
  localparam logic [1:0]      RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_B, ST_HOLD} state_e;
  typedef enum logic [1:0] {TGT_NONE, TGT_S0, TGT_S1, TGT_SD} tgt_e;

  state_e           state_q, state_d;
  tgt_e             target_q, target_d;
  logic [IDW_M-1:0] awid_q, awid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bvalid_q, bvalid_d;
  logic [IDW_M-1:0] bid_q, bid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_allow_q, aw_allow_d;

  logic hs_s0, hs_s1, hs_sd;
  assign hs_s0 = bus.AWVALID_S0 & bus.AWREADY_S0;
  assign hs_s1 = bus.AWVALID_S1 & bus.AWREADY_S1;
  assign hs_sd = bus.AWVALID_SD & bus.AWREADY_SD;

  // Only the low IDW_M bits of a slave ID carry the master ID; the rest is ignored.
  logic unused_bid_hi;
  assign unused_bid_hi = ^{bus.BID_S0[IDW_S-1:IDW_M], bus.BID_S1[IDW_S-1:IDW_M],
                           bus.BID_SD[IDW_S-1:IDW_M]};

  logic             tgt_bvalid;
  logic [IDW_M-1:0] tgt_bid;
  logic [1:0]       tgt_bresp;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tgt_bvalid = 1'b0;
    tgt_bid    = '0;
    tgt_bresp  = '0;
    case (target_q)
      TGT_S0:  begin tgt_bvalid = bus.BVALID_S0; tgt_bid = bus.BID_S0[IDW_M-1:0]; tgt_bresp = bus.BRESP_S0; end
      TGT_S1:  begin tgt_bvalid = bus.BVALID_S1; tgt_bid = bus.BID_S1[IDW_M-1:0]; tgt_bresp = bus.BRESP_S1; end
      TGT_SD:  begin tgt_bvalid = bus.BVALID_SD; tgt_bid = bus.BID_SD[IDW_M-1:0]; tgt_bresp = bus.BRESP_SD; end
      default: ;
    endcase
  end

  logic bready_s0, bready_s1, bready_sd;

  // Idle sinks any stale response; gated by rst so nothing is acknowledged while held in reset.
  always_comb begin
    bready_s0 = 1'b0;
    bready_s1 = 1'b0;
    bready_sd = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          bready_s0 = bus.BVALID_S0;
          bready_s1 = bus.BVALID_S1;
          bready_sd = bus.BVALID_SD;
        end
        ST_WAIT_B: begin
          bready_s0 = (target_q == TGT_S0);
          bready_s1 = (target_q == TGT_S1);
          bready_sd = (target_q == TGT_SD);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    awid_d     = awid_q;
    cnt_d      = cnt_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    aw_allow_d = aw_allow_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s0 || hs_s1 || hs_sd) begin
          target_d   = hs_s0 ? TGT_S0 : (hs_s1 ? TGT_S1 : TGT_SD);
          awid_d     = bus.AWID_M1;
          cnt_d      = '0;
          aw_allow_d = 1'b0;
          state_d    = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (tgt_bvalid) begin
          bid_d    = tgt_bid;
          bresp_d  = tgt_bresp;
          bvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end else if (TO_CYC != 0 && cnt_q == TO_LAST) begin
          bid_d    = awid_q;
          bresp_d  = RESP_DECERR;
          bvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.BREADY_M1) begin
          bvalid_d   = 1'b0;
          target_d   = TGT_NONE;
          aw_allow_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      target_q   <= TGT_NONE;
      awid_q     <= '0;
      cnt_q      <= '0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      aw_allow_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      awid_q     <= awid_d;
      cnt_q      <= cnt_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      aw_allow_q <= aw_allow_d;
    end
  end

  assign bus.AW_ALLOW  = aw_allow_q;
  assign bus.BVALID_M1 = bvalid_q;
  assign bus.BID_M1    = bid_q;
  assign bus.BRESP_M1  = bresp_q;
  assign bus.BREADY_S0 = bready_s0;
  assign bus.BREADY_S1 = bready_s1;
  assign bus.BREADY_SD = bready_sd;

endmodule
